// File: rtl/seg7_counter_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_counter_display
// Description : Multi-digit BCD/hex up/down counter with a prescaled step,
//               bus load and registered active-low 7-segment decode.
//               Optional leading-zero blanking: LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_counter_display #(
    parameter int NUM_DIGITS = 6,
    parameter int PRESCALE_W = 24,
    parameter int BCD_MODE   = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    Reset_7Seg,
    input  logic                    Load_Flag,
    input  logic [4*NUM_DIGITS-1:0] Load_Value,
    input  logic                    Count_En,
    input  logic                    Count_Down,
    output logic [4*NUM_DIGITS-1:0] Digits,
    output logic [7*NUM_DIGITS-1:0] Seg_Out,
    output logic                    Rollover
);

    localparam logic [3:0] C_MAX_DIGIT = (BCD_MODE != 0) ? 4'd9 : 4'd15;
    localparam logic [6:0] C_SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

    logic [PRESCALE_W-1:0]   r_presc_q, w_presc_d;
    logic [4*NUM_DIGITS-1:0] r_digits_q, w_digits_d;
    logic [4*NUM_DIGITS-1:0] w_step, w_load;
    logic [7*NUM_DIGITS-1:0] r_seg_q, w_seg_d, w_seg_rst;
    logic                    r_roll_q, w_roll_d;
    logic                    w_tick, w_carry;
    logic [3:0]              w_nib;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick = Count_En & (&r_presc_q);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] w_ld_nib;
            logic [3:0] w_cur_nib;
            logic       w_upper_zero;

            assign w_ld_nib  = Load_Value[4*gi +: 4];
            assign w_cur_nib = r_digits_q[4*gi +: 4];
            assign w_upper_zero = ~|r_digits_q[4*NUM_DIGITS-1:4*gi];
            assign w_load[4*gi +: 4] = (w_ld_nib > C_MAX_DIGIT) ? C_MAX_DIGIT : w_ld_nib;

`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign w_seg_d[6:0]   = f_decode(w_cur_nib);
                assign w_seg_rst[6:0] = C_SEG_ZERO;
            end else begin : g_upper
                assign w_seg_d[7*gi +: 7]   = w_upper_zero ? C_SEG_BLANK : f_decode(w_cur_nib);
                assign w_seg_rst[7*gi +: 7] = C_SEG_BLANK;
            end
`else
            assign w_seg_d[7*gi +: 7]   = f_decode(w_cur_nib);
            assign w_seg_rst[7*gi +: 7] = C_SEG_ZERO;
`endif
        end
    endgenerate

    // Ripple step: each digit moves only while the carry/borrow is still live.
    always_comb begin
        w_step  = r_digits_q;
        w_carry = 1'b1;
        w_nib   = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_nib = r_digits_q[4*i +: 4];
            if (w_carry) begin
                if (Count_Down) begin
                    if (w_nib == 4'd0) begin
                        w_step[4*i +: 4] = C_MAX_DIGIT;
                    end else begin
                        w_step[4*i +: 4] = w_nib - 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (w_nib == C_MAX_DIGIT) begin
                        w_step[4*i +: 4] = 4'd0;
                    end else begin
                        w_step[4*i +: 4] = w_nib + 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_presc_d  = r_presc_q;
        w_digits_d = r_digits_q;
        w_roll_d   = 1'b0;
        if (Load_Flag) begin
            w_digits_d = w_load;
            w_presc_d  = '0;
        end else begin
            if (Count_En) begin
                w_presc_d = r_presc_q + PRESCALE_W'(1);
            end
            if (w_tick) begin
                w_digits_d = w_step;
                w_roll_d   = w_carry;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset_7Seg) begin
            r_presc_q  <= '0;
            r_digits_q <= '0;
            r_roll_q   <= 1'b0;
            r_seg_q    <= w_seg_rst;
        end else begin
            r_presc_q  <= w_presc_d;
            r_digits_q <= w_digits_d;
            r_roll_q   <= w_roll_d;
            r_seg_q    <= w_seg_d;
        end
    end

    assign Digits   = r_digits_q;
    assign Seg_Out  = r_seg_q;
    assign Rollover = r_roll_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_counter_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_counter_display
// Description : Self-checking bench: three counter instances (BCD 2-digit,
//               hex 2-digit, BCD 3-digit) against an integer-valued model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_counter_display;

    logic        clk = 1'b0;
    logic        rst, en, dn, ld;
    logic [11:0] lv;

    logic [7:0]  dig_a, dig_b;
    logic [11:0] dig_c;
    logic [13:0] seg_a, seg_b;
    logic [20:0] seg_c;
    logic        roll_a, roll_b, roll_c;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    seg7_counter_display #(.NUM_DIGITS(2), .PRESCALE_W(2), .BCD_MODE(1)) u_a (
        .CLOCK_50(clk), .Reset_7Seg(rst), .Load_Flag(ld), .Load_Value(lv[7:0]),
        .Count_En(en), .Count_Down(dn), .Digits(dig_a), .Seg_Out(seg_a), .Rollover(roll_a));

    seg7_counter_display #(.NUM_DIGITS(2), .PRESCALE_W(2), .BCD_MODE(0)) u_b (
        .CLOCK_50(clk), .Reset_7Seg(rst), .Load_Flag(ld), .Load_Value(lv[7:0]),
        .Count_En(en), .Count_Down(dn), .Digits(dig_b), .Seg_Out(seg_b), .Rollover(roll_b));

    seg7_counter_display #(.NUM_DIGITS(3), .PRESCALE_W(2), .BCD_MODE(1)) u_c (
        .CLOCK_50(clk), .Reset_7Seg(rst), .Load_Flag(ld), .Load_Value(lv),
        .Count_En(en), .Count_Down(dn), .Digits(dig_c), .Seg_Out(seg_c), .Rollover(roll_c));

    // Model: counter held as a plain integer modulo R^N.
    int radix [3] = '{10, 16, 10};
    int ndig  [3] = '{2, 2, 3};
    int m_val [3] = '{0, 0, 0};
    int m_segv[3] = '{0, 0, 0};
    bit m_roll[3] = '{1'b0, 1'b0, 1'b0};
    int m_pre     = 0;
    bit m_tick;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic int pw(input int r, input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * r;
        return p;
    endfunction

    function automatic logic [63:0] to_dig(input int v, input int r, input int n);
        logic [63:0] res = '0;
        for (int i = 0; i < n; i++) begin
            res[4*i +: 4] = 4'((v / pw(r, i)) % r);
        end
        return res;
    endfunction

    function automatic int from_load(input logic [11:0] val, input int r, input int n);
        int acc = 0;
        int nib;
        for (int i = 0; i < n; i++) begin
            nib = int'(val[4*i +: 4]);
            if (r == 10 && nib > 9) nib = 9;
            acc = acc + nib * pw(r, i);
        end
        return acc;
    endfunction

    function automatic logic [63:0] to_seg(input int v, input int r, input int n);
        logic [63:0] res = '0;
        logic [6:0]  f;
        for (int i = 0; i < n; i++) begin
            f = seg_tbl[(v / pw(r, i)) % r];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && (v / pw(r, i)) == 0) f = 7'b1111111;
`endif
            res[7*i +: 7] = f;
        end
        return res;
    endfunction

    always @(posedge clk) begin
        m_tick = en && (m_pre == 3);
        if (rst) begin
            m_pre = 0;
            for (int k = 0; k < 3; k++) begin
                m_val[k] = 0; m_segv[k] = 0; m_roll[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) m_segv[k] = m_val[k];
            if (ld) begin
                m_pre = 0;
                for (int k = 0; k < 3; k++) begin
                    m_val[k]  = from_load(lv, radix[k], ndig[k]);
                    m_roll[k] = 1'b0;
                end
            end else begin
                if (en) m_pre = (m_pre + 1) % 4;
                for (int k = 0; k < 3; k++) begin
                    m_roll[k] = 1'b0;
                    if (m_tick) begin
                        if (dn) begin
                            m_roll[k] = (m_val[k] == 0);
                            m_val[k]  = (m_val[k] == 0) ? pw(radix[k], ndig[k]) - 1 : m_val[k] - 1;
                        end else begin
                            m_roll[k] = (m_val[k] == pw(radix[k], ndig[k]) - 1);
                            m_val[k]  = (m_val[k] + 1) % pw(radix[k], ndig[k]);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                logic [63:0] ad, as;
                logic        ar;
                ad = (k == 0) ? {56'b0, dig_a} : (k == 1) ? {56'b0, dig_b} : {52'b0, dig_c};
                as = (k == 0) ? {50'b0, seg_a} : (k == 1) ? {50'b0, seg_b} : {43'b0, seg_c};
                ar = (k == 0) ? roll_a : (k == 1) ? roll_b : roll_c;
                check($sformatf("model_digits[%0d]", k), ad, to_dig(m_val[k], radix[k], ndig[k]));
                check($sformatf("model_seg[%0d]", k), as, to_seg(m_segv[k], radix[k], ndig[k]));
                check($sformatf("model_roll[%0d]", k), {63'b0, ar}, {63'b0, m_roll[k]});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [11:0] v);
        ld = 1'b1; lv = v;
        cyc(1);
        ld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dn = 1'b0; ld = 1'b0; lv = '0;
        cyc(2);
        chk_on = 1'b1;
        check("rst_digits", {56'b0, dig_a}, 64'h00);
`ifdef LEADING_ZERO_BLANK_EN
        check("rst_seg", {50'b0, seg_a}, {50'b0, 14'b1111111_1000000});
`else
        check("rst_seg", {50'b0, seg_a}, {50'b0, 14'b1000000_1000000});
`endif
        check("rst_roll", {63'b0, roll_a}, 64'h0);
        rst = 1'b0;

        // BCD up wrap 98 -> 99 -> 00
        load(12'h098); en = 1'b1;
        cyc(4); check("up_98_99", {56'b0, dig_a}, 64'h99);
        cyc(4); check("up_99_00", {56'b0, dig_a}, 64'h00);
        check("up_roll", {63'b0, roll_a}, 64'h1);
        check("hex_99_9a", {56'b0, dig_b}, 64'h9a);
        cyc(1); check("roll_pulse_end", {63'b0, roll_a}, 64'h0);
        en = 1'b0;

        // Down wrap from zero, then borrow from 10
        load(12'h000); en = 1'b1; dn = 1'b1;
        cyc(4);
        check("dn_bcd_wrap", {56'b0, dig_a}, 64'h99);
        check("dn_bcd_roll", {63'b0, roll_a}, 64'h1);
        check("dn_hex_wrap", {56'b0, dig_b}, 64'hff);
        check("dn_hex_roll", {63'b0, roll_b}, 64'h1);
        en = 1'b0;
        load(12'h010); en = 1'b1;
        cyc(4);
        check("dn_bcd_10", {56'b0, dig_a}, 64'h09);
        check("dn_hex_10", {56'b0, dig_b}, 64'h0f);
        en = 1'b0; dn = 1'b0;

        // Clamp on load, then load colliding with a tick
        load(12'h0C3);
        check("clamp_a", {56'b0, dig_a}, 64'h93);
        check("noclamp_b", {56'b0, dig_b}, 64'hc3);
        check("clamp_c", {52'b0, dig_c}, 64'h093);
        en = 1'b1;
        cyc(3);
        load(12'h042);
        check("load_tick_val", {56'b0, dig_a}, 64'h42);
        check("load_tick_roll", {63'b0, roll_a}, 64'h0);
        cyc(3); check("after_load_hold", {56'b0, dig_a}, 64'h42);
        cyc(1); check("after_load_step", {56'b0, dig_a}, 64'h43);

        // Hold with Count_En low, then reset mid-count
        en = 1'b0;
        cyc(100);
        check("hold_digits", {56'b0, dig_a}, 64'h43);
        check("hold_seg", {50'b0, seg_a}, {50'b0, 14'b0011001_0110000});
        load(12'h057); en = 1'b1;
        check("pre_rst", {56'b0, dig_a}, 64'h57);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("mid_rst", {56'b0, dig_a}, 64'h00);
        en = 1'b0;

        // Leading-zero handling on the 3-digit instance
        load(12'h005); cyc(1);
`ifdef LEADING_ZERO_BLANK_EN
        check("lzb_005", {43'b0, seg_c}, {43'b0, 21'b1111111_1111111_0010010});
`else
        check("lzb_005", {43'b0, seg_c}, {43'b0, 21'b1000000_1000000_0010010});
`endif
        load(12'h000); cyc(1);
        check("lzb_000_d0", {57'b0, seg_c[6:0]}, {57'b0, 7'b1000000});

        // Free-running hex/BCD mix checked against the model
        en = 1'b1; load(12'h9FE);
        cyc(20); dn = 1'b1; cyc(20);
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
